// File: rtl/video_argmax_frame_gate.sv
// Frame-level gate placed after the argmax stage. At each start-of-frame beat
// it decides whether the whole frame is forwarded, dropped for decimation, or
// discarded because software has disabled output. The output stage is a single
// register slice with AXI4-Stream backpressure.
module video_argmax_frame_gate #(
    parameter int TUSER_WIDTH  = 1,
    parameter int TDATA_WIDTH  = 10,
    parameter int ARGMAX_WIDTH = 8,
    parameter int SKIP_WIDTH   = 8,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                    reset,
    input  logic                    clk,

    input  logic                    ctl_enable,
    input  logic [SKIP_WIDTH-1:0]   ctl_skip,

    output logic                    stat_busy,
    output logic [COUNT_WIDTH-1:0]  stat_frame_count,
    output logic [COUNT_WIDTH-1:0]  stat_drop_count,

    input  logic [TUSER_WIDTH-1:0]  s_axi4s_tuser,
    input  logic                    s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0]  s_axi4s_tdata,
    input  logic [ARGMAX_WIDTH-1:0] s_axi4s_targmax,
    input  logic                    s_axi4s_tvalid,
    output logic                    s_axi4s_tready,

    output logic [TUSER_WIDTH-1:0]  m_axi4s_tuser,
    output logic                    m_axi4s_tlast,
    output logic [TDATA_WIDTH-1:0]  m_axi4s_tdata,
    output logic [ARGMAX_WIDTH-1:0] m_axi4s_targmax,
    output logic                    m_axi4s_tvalid,
    input  logic                    m_axi4s_tready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [SKIP_WIDTH-1:0]   skip_cnt;
    logic [SKIP_WIDTH-1:0]   skip_next;
    logic                    frame_inc;
    logic                    drop_inc;

    logic                    cke;
    logic                    accept;
    logic                    sof;
    logic                    forward;

    // The output slot can take a new beat when it is empty or being drained.
    assign cke            = m_axi4s_tready | ~m_axi4s_tvalid;
    assign s_axi4s_tready = cke;
    assign accept         = s_axi4s_tvalid & cke;
    assign sof            = accept & s_axi4s_tuser[0];

    // On a non-SOF beat state_next equals state, so this covers both cases.
    assign forward        = accept & (state_next == PASS);

    // Frame decision: only an accepted SOF beat can change state, and the
    // chosen state already governs that SOF beat.
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        frame_inc  = 1'b0;
        drop_inc   = 1'b0;
        if (sof) begin
            if (!ctl_enable) begin
                state_next = IDLE;
                skip_next  = '0;
            end else if (skip_cnt == '0) begin
                state_next = PASS;
                skip_next  = ctl_skip;
                frame_inc  = 1'b1;
            end else begin
                state_next = DROP;
                skip_next  = skip_cnt - SKIP_WIDTH'(1);
                drop_inc   = 1'b1;
            end
        end
    end

    // Frame state, decimation counter and status registers advance on accepted beats only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            skip_cnt         <= '0;
            stat_busy        <= 1'b0;
            stat_frame_count <= '0;
            stat_drop_count  <= '0;
        end else if (accept) begin
            state     <= state_next;
            skip_cnt  <= skip_next;
            stat_busy <= (state_next == PASS);
            if (frame_inc) begin
                stat_frame_count <= stat_frame_count + COUNT_WIDTH'(1);
            end
            if (drop_inc) begin
                stat_drop_count <= stat_drop_count + COUNT_WIDTH'(1);
            end
        end
    end

    // Output register slice; everything holds while the downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_axi4s_tvalid  <= 1'b0;
            m_axi4s_tuser   <= '0;
            m_axi4s_tlast   <= 1'b0;
            m_axi4s_tdata   <= '0;
            m_axi4s_targmax <= '0;
        end else if (cke) begin
            m_axi4s_tvalid <= forward;
            if (accept) begin
                m_axi4s_tuser   <= s_axi4s_tuser;
                m_axi4s_tlast   <= s_axi4s_tlast;
                m_axi4s_tdata   <= s_axi4s_tdata;
                m_axi4s_targmax <= s_axi4s_targmax;
            end
        end
    end

endmodule

// File: tb/tb_video_argmax_frame_gate.sv
// Directed self-checking bench for video_argmax_frame_gate. Frames are 4x2
// pixels; beat b of frame f carries tdata = f*16+b and targmax = 0x40+f*8+b.
module tb_video_argmax_frame_gate;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctl_enable = 1'b0;
    logic [7:0]  ctl_skip = 8'd0;
    logic        stat_busy;
    logic [31:0] stat_frame_count;
    logic [31:0] stat_drop_count;
    logic [0:0]  s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic [9:0]  s_tdata = 10'd0;
    logic [7:0]  s_targmax = 8'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [0:0]  m_tuser;
    logic        m_tlast;
    logic [9:0]  m_tdata;
    logic [7:0]  m_targmax;
    logic        m_tvalid;
    logic        m_tready = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    bit         bp_mode = 1'b0;
    logic [19:0] got_q[$];
    int         stable_viol = 0;
    int         hold_checks = 0;
    bit         hold_prev = 1'b0;
    logic [20:0] prev_out = '0;

    video_argmax_frame_gate dut (
        .reset            (reset),
        .clk              (clk),
        .ctl_enable       (ctl_enable),
        .ctl_skip         (ctl_skip),
        .stat_busy        (stat_busy),
        .stat_frame_count (stat_frame_count),
        .stat_drop_count  (stat_drop_count),
        .s_axi4s_tuser    (s_tuser),
        .s_axi4s_tlast    (s_tlast),
        .s_axi4s_tdata    (s_tdata),
        .s_axi4s_targmax  (s_targmax),
        .s_axi4s_tvalid   (s_tvalid),
        .s_axi4s_tready   (s_tready),
        .m_axi4s_tuser    (m_tuser),
        .m_axi4s_tlast    (m_tlast),
        .m_axi4s_tdata    (m_tdata),
        .m_axi4s_targmax  (m_targmax),
        .m_axi4s_tvalid   (m_tvalid),
        .m_axi4s_tready   (m_tready)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Downstream ready: always ready, or a coin toss per cycle in backpressure mode.
    always @(posedge clk) begin
        #1;
        if (bp_mode) m_tready = ($urandom_range(0, 1) == 1);
        else         m_tready = 1'b1;
    end

    // Output monitor at the falling edge: logs completed handshakes and checks hold-stability.
    always @(negedge clk) begin
        if (bp_mode) begin
            if (hold_prev) begin
                hold_checks++;
                if ({m_tvalid, m_tuser, m_tlast, m_tdata, m_targmax} !== prev_out) stable_viol++;
            end
            if (m_tvalid && m_tready) got_q.push_back({m_tuser, m_tlast, m_tdata, m_targmax});
            hold_prev = m_tvalid && !m_tready;
            prev_out  = {m_tvalid, m_tuser, m_tlast, m_tdata, m_targmax};
        end else begin
            hold_prev = 1'b0;
        end
    end

    function automatic logic [19:0] beat_word(input int f, input int b);
        logic [9:0] d;
        logic [7:0] a;
        d = 10'(f * 16 + b);
        a = 8'(8'h40 + f * 8 + b);
        return {(b == 0), (b == 3 || b == 7), d, a};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Presents one beat, waits (bounded) for the handshake, optionally checks the registered result.
    task automatic apply_stimulus(input int f, input int b, input bit exp_pass, input bit do_check);
        logic [19:0] w;
        int waited;
        w = beat_word(f, b);
        s_tuser   = w[19];
        s_tlast   = w[18];
        s_tdata   = w[17:8];
        s_targmax = w[7:0];
        s_tvalid  = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!s_tready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 100) check_output("tready_timeout", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        if (do_check) begin
            check_output($sformatf("tvalid f%0d b%0d", f, b), 32'(m_tvalid), 32'(exp_pass));
            check_output($sformatf("busy f%0d b%0d", f, b), 32'(stat_busy), 32'(exp_pass));
            if (exp_pass)
                check_output($sformatf("beat f%0d b%0d", f, b),
                             32'({m_tuser, m_tlast, m_tdata, m_targmax}), 32'(w));
        end
    endtask

    // Sends beats first..7 of frame f; drops ctl_enable just before beat disable_at (-1 = never).
    task automatic send_frame(input int f, input bit exp_pass, input int first, input int disable_at, input bit do_check);
        for (int b = first; b < 8; b++) begin
            if (b == disable_at) ctl_enable = 1'b0;
            apply_stimulus(f, b, exp_pass, do_check);
        end
    endtask

    initial begin
        int waited;
        logic [19:0] exp_w;
        int exp_frames[2];

        $display("[TB] reset state");
        do_reset();
        check_output("rst tvalid", 32'(m_tvalid), 32'd0);
        check_output("rst tdata", 32'(m_tdata), 32'd0);
        check_output("rst busy", 32'(stat_busy), 32'd0);
        check_output("rst frames", stat_frame_count, 32'd0);
        check_output("rst drops", stat_drop_count, 32'd0);
        check_output("rst s_tready", 32'(s_tready), 32'd1);

        $display("[TB] skip=0, three frames all forwarded");
        ctl_enable = 1'b1;
        ctl_skip = 8'd0;
        for (int f = 0; f < 3; f++) send_frame(f, 1'b1, 0, -1, 1'b1);
        s_tvalid = 1'b0;
        check_output("t1 frames", stat_frame_count, 32'd3);
        check_output("t1 drops", stat_drop_count, 32'd0);

        $display("[TB] skip=2, seven frames");
        do_reset();
        ctl_enable = 1'b1;
        ctl_skip = 8'd2;
        for (int f = 0; f < 7; f++) send_frame(f, (f % 3) == 0, 0, -1, 1'b1);
        s_tvalid = 1'b0;
        check_output("t2 frames", stat_frame_count, 32'd3);
        check_output("t2 drops", stat_drop_count, 32'd4);

        $display("[TB] enable dropped mid-frame");
        do_reset();
        ctl_enable = 1'b1;
        ctl_skip = 8'd0;
        send_frame(0, 1'b1, 0, -1, 1'b1);
        send_frame(1, 1'b1, 0, 2, 1'b1);
        send_frame(2, 1'b0, 0, -1, 1'b1);
        s_tvalid = 1'b0;
        check_output("t3 frames", stat_frame_count, 32'd2);
        check_output("t3 drops", stat_drop_count, 32'd0);

        $display("[TB] random downstream ready, skip=1");
        do_reset();
        ctl_enable = 1'b1;
        ctl_skip = 8'd1;
        got_q.delete();
        bp_mode = 1'b1;
        for (int f = 0; f < 4; f++) send_frame(f, 1'b0, 0, -1, 1'b0);
        s_tvalid = 1'b0;
        waited = 0;
        @(negedge clk);
        while (m_tvalid && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        check_output("t4 drain", 32'(m_tvalid), 32'd0);
        bp_mode = 1'b0;
        @(posedge clk);
        #1;
        check_output("t4 beat count", 32'(got_q.size()), 32'd16);
        exp_frames[0] = 0;
        exp_frames[1] = 2;
        for (int i = 0; i < 16; i++) begin
            exp_w = beat_word(exp_frames[i / 8], i % 8);
            if (i < got_q.size()) check_output($sformatf("t4 beat %0d", i), 32'(got_q[i]), 32'(exp_w));
        end
        check_output("t4 hold stable", 32'(stable_viol), 32'd0);
        check_output("t4 frames", stat_frame_count, 32'd2);
        check_output("t4 drops", stat_drop_count, 32'd2);

        $display("[TB] reset mid-frame, then resume at next SOF");
        ctl_skip = 8'd0;
        do_reset();
        ctl_enable = 1'b1;
        for (int b = 0; b < 3; b++) apply_stimulus(5, b, 1'b1, 1'b1);
        check_output("t5 pre tvalid", 32'(m_tvalid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_output("t5 async tvalid", 32'(m_tvalid), 32'd0);
        check_output("t5 async frames", stat_frame_count, 32'd0);
        check_output("t5 async busy", 32'(stat_busy), 32'd0);
        check_output("t5 async tdata", 32'(m_tdata), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        send_frame(5, 1'b0, 3, -1, 1'b1);
        send_frame(6, 1'b1, 0, -1, 1'b1);
        s_tvalid = 1'b0;
        check_output("t5 frames", stat_frame_count, 32'd1);
        check_output("t5 drops", stat_drop_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_argmax_frame_gate.md
Name: video_argmax_frame_gate

Overview:
- Frame-level scheduler in front of the segmentation overlay/DMA, after the argmax stage.
- Consumes the AXI4-Stream carrying pixel data plus per-pixel argmax class.
- Decides, at each frame start only, whether the whole frame is forwarded or dropped. The decision uses a software enable and a frame-decimation (skip) setting.
- Provides frame/drop counters for status registers.

Parameters:
TUSER_WIDTH, 1, width of tuser; bit 0 is start-of-frame (SOF)
TDATA_WIDTH, 10, pixel data width
ARGMAX_WIDTH, 8, argmax class index width
SKIP_WIDTH, 8, width of decimation setting
COUNT_WIDTH, 32, width of status counters

Ports:
reset  in  1  asynchronous reset, active-high
clk  in  1  clock
ctl_enable  in  1  forward frames when 1; sampled only at SOF
ctl_skip  in  SKIP_WIDTH  frames dropped after each forwarded frame; sampled only at SOF
stat_busy  out  1  1 while current frame is being forwarded (state PASS)
stat_frame_count  out  COUNT_WIDTH  number of forwarded frames
stat_drop_count  out  COUNT_WIDTH  number of frames dropped by decimation while enabled
s_axi4s_tuser  in  TUSER_WIDTH  input user (bit0 = SOF)
s_axi4s_tlast  in  1  input end-of-line
s_axi4s_tdata  in  TDATA_WIDTH  input pixel
s_axi4s_targmax  in  ARGMAX_WIDTH  input class index
s_axi4s_tvalid  in  1  input valid
s_axi4s_tready  out  1  input ready
m_axi4s_tuser  out  TUSER_WIDTH  output user
m_axi4s_tlast  out  1  output end-of-line
m_axi4s_tdata  out  TDATA_WIDTH  output pixel
m_axi4s_targmax  out  ARGMAX_WIDTH  output class index
m_axi4s_tvalid  out  1  output valid
m_axi4s_tready  in  1  output ready

Behaviour:
- cke = m_axi4s_tready | ~m_axi4s_tvalid; s_axi4s_tready = cke in every state. Ready never depends on input tdata or tuser.
- Accepted beat: s_tvalid & s_tready. SOF beat: accepted beat with tuser[0]=1.
- States: IDLE (discard, not enabled), PASS (forward), DROP (discard, decimating). All registers are updated only on accepted beats.
- At each SOF beat, the new state is decided and applies to that beat itself:
  - ctl_enable=0 -> IDLE; skip_cnt <= 0.
  - ctl_enable=1 and skip_cnt==0 -> PASS; skip_cnt <= ctl_skip; stat_frame_count += 1.
  - ctl_enable=1 and skip_cnt!=0 -> DROP; skip_cnt -= 1; stat_drop_count += 1.
- Non-SOF beats keep the current state. A frame is never truncated. Enable and skip changes mid-frame take effect at the next SOF only.
- Beats received before the first SOF after reset are discarded (state IDLE).
- Output register: 1-cycle latency. When cke:
  - m_tvalid <= forwarded beat, i.e. accepted & (SOF ? decision==PASS : state==PASS).
  - m_tuser, m_tlast, m_tdata and m_targmax load from the input on accepted beats.
  - When ~cke, all outputs hold (AXI stable under backpressure).
- Consequence of the decision rules:
  - ctl_skip=N yields pattern pass, N drops, pass, ...
  - The first enabled SOF always passes, because skip_cnt is 0 after IDLE.
- Counters wrap modulo 2^COUNT_WIDTH without saturation. IDLE frames are not counted.
- stat_busy = (state==PASS), registered.
- Simultaneous events: an SOF beat arriving while m holds an un-accepted beat is not accepted until cke=1. The decision is made in the accept cycle, using ctl values at that cycle.
- Reset (async, any time, including mid-frame) forces:
  - state IDLE, skip_cnt 0, counters 0, stat_busy 0;
  - m_tvalid 0; m_tuser, m_tlast, m_tdata and m_targmax 0.
- After reset release, the output resumes only at the next SOF.

Test Plan:
- Enable=1, skip=0, 3 frames of 4x2 pixels, m_tready=1 -> all 24 beats out, 1-cycle latency, data/argmax identical; frame_count=3, drop_count=0.
- Enable=1, skip=2, 7 frames -> frames 0,3,6 forwarded; frame_count=3, drop_count=4; stat_busy high only during frames 0,3,6.
- Enable toggled 1->0 mid-frame 1 -> frame 1 completes fully (all beats incl. last tlast). Frame 2 is discarded and neither counter increments.
- Random m_tready (50%) with skip=1 -> no beat lost or duplicated in forwarded frames; m outputs stable while m_tvalid & ~m_tready.
- Reset asserted mid-frame while m_tvalid=1 -> m_tvalid=0 and counters 0 immediately. Remaining beats of that frame are discarded; the next SOF is forwarded.
- Stream started mid-frame (no SOF) with enable=1 -> nothing output until first SOF; that frame passes.
